// File: rtl/gray_ptr_sync_if.sv
// Bundle for one gray pointer crossing: foreign gray word in, decoded binary/step/error status out.
// The driving side takes the master view; the synchroniser takes the slave view.
interface gray_ptr_sync_if #(
  parameter int DATA_WIDTH = 4
);
  logic [DATA_WIDTH-1:0] gray_data_i;
  logic                  clr_err_i;
  logic [DATA_WIDTH-1:0] gray_sync_o;
  logic [DATA_WIDTH-1:0] bin_data_o;
  logic                  update_o;
  logic [DATA_WIDTH-1:0] delta_o;
  logic                  err_o;
  logic                  err_sticky_o;

  modport master (
    output gray_data_i, clr_err_i,
    input  gray_sync_o, bin_data_o, update_o, delta_o, err_o, err_sticky_o
  );

  modport slave (
    input  gray_data_i, clr_err_i,
    output gray_sync_o, bin_data_o, update_o, delta_o, err_o, err_sticky_o
  );
endinterface

// File: rtl/gray_ptr_sync.sv
// Resynchronises a foreign gray word and decodes it to binary with update/step/error flags.
// Latency SYNC_STAGES+1 edges from input to outputs; no backpressure, a new sample every cycle.
module gray_ptr_sync #(
  parameter int DATA_WIDTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  gray_ptr_sync_if.slave    bus
);

  logic [DATA_WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [DATA_WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [DATA_WIDTH-1:0] gray_q, gray_d;
  logic [DATA_WIDTH-1:0] bin_q, bin_d;
  logic                  update_q, update_d;
  logic [DATA_WIDTH-1:0] delta_q, delta_d;
  logic                  err_q, err_d;
  logic                  sticky_q, sticky_d;
  logic [DATA_WIDTH-1:0] gray_s;
  logic [DATA_WIDTH-1:0] diff;

  function automatic logic [DATA_WIDTH-1:0] g2b(input logic [DATA_WIDTH-1:0] g);
    logic [DATA_WIDTH-1:0] b;
    b[DATA_WIDTH-1] = g[DATA_WIDTH-1];
    for (int i = DATA_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  assign gray_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d[0] = bus.gray_data_i;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
    gray_d   = gray_s;
    bin_d    = g2b(gray_s);
    diff     = gray_s ^ gray_q;
    update_d = (diff != '0);
    delta_d  = update_d ? (bin_d - bin_q) : '0;
    // Clearing the lowest set bit leaves something only if two or more bits differ.
    err_d    = ((diff & (diff - DATA_WIDTH'(1))) != '0);
    sticky_d = err_d | (sticky_q & ~bus.clr_err_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
      gray_q   <= '0;
      bin_q    <= '0;
      update_q <= 1'b0;
      delta_q  <= '0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_d[k];
      end
      gray_q   <= gray_d;
      bin_q    <= bin_d;
      update_q <= update_d;
      delta_q  <= delta_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
    end
  end

  assign bus.gray_sync_o  = gray_q;
  assign bus.bin_data_o   = bin_q;
  assign bus.update_o     = update_q;
  assign bus.delta_o      = delta_q;
  assign bus.err_o        = err_q;
  assign bus.err_sticky_o = sticky_q;

endmodule

// File: tb/tb_gray_ptr_sync.sv
// Randomised and directed bench for gray_ptr_sync; a delay-line reference model feeds a scoreboard queue.
module tb_gray_ptr_sync;
  localparam int W = 4;
  localparam int S = 2;

  typedef struct packed {
    logic [W-1:0] g;
    logic [W-1:0] b;
    logic         upd;
    logic [W-1:0] d;
    logic         err;
    logic         stk;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gray_ptr_sync_if #(.DATA_WIDTH(W)) bus ();
  gray_ptr_sync #(.DATA_WIDTH(W), .SYNC_STAGES(S)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  exp_t         exp_q [$];
  logic [W-1:0] hist  [$];
  logic [W-1:0] m_prev_g, m_prev_b, m_g, m_b;
  logic         m_stk;
  exp_t         m_e, c_e;
  int           checks = 0;
  int           passes = 0;
  int           cur_b  = 0;

  function automatic logic [W-1:0] to_gray(input int b);
    logic [W-1:0] bv;
    bv = W'(b);
    return bv ^ (bv >> 1);
  endfunction

  // Decode by search: the binary value whose gray encoding matches.
  function automatic logic [W-1:0] ref_bin(input logic [W-1:0] g);
    for (int b = 0; b < (1 << W); b++) begin
      if (to_gray(b) == g) return W'(b);
    end
    return '0;
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] expv);
    checks++;
    if (act !== expv) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    else passes++;
  endtask

  // Reference model: the value reaching the decode register is the input sampled S edges earlier.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hist.delete();
      for (int i = 0; i < S; i++) hist.push_back('0);
      m_prev_g = '0;
      m_prev_b = '0;
      m_stk    = 1'b0;
      exp_q.delete();
    end else begin
      hist.push_back(bus.gray_data_i);
      m_g     = hist.pop_front();
      m_b     = ref_bin(m_g);
      m_e.g   = m_g;
      m_e.b   = m_b;
      m_e.upd = (m_g != m_prev_g);
      m_e.d   = m_e.upd ? W'((int'(m_b) - int'(m_prev_b) + (1 << W)) % (1 << W)) : '0;
      m_e.err = ($countones(m_g ^ m_prev_g) > 1);
      m_stk   = m_e.err | (m_stk & ~bus.clr_err_i);
      m_e.stk = m_stk;
      m_prev_g = m_g;
      m_prev_b = m_b;
      exp_q.push_back(m_e);
    end
  end

  // Monitor: outputs sampled shortly after each rising edge.
  always @(posedge clk) begin
    #2;
    if (rst) begin
      chk("rst_gray", bus.gray_sync_o, '0);
      chk("rst_bin", bus.bin_data_o, '0);
      chk("rst_upd", W'(bus.update_o), '0);
      chk("rst_delta", bus.delta_o, '0);
      chk("rst_err", W'(bus.err_o), '0);
      chk("rst_sticky", W'(bus.err_sticky_o), '0);
    end else if (exp_q.size() > 0) begin
      c_e = exp_q.pop_front();
      chk("gray_sync", bus.gray_sync_o, c_e.g);
      chk("bin_data", bus.bin_data_o, c_e.b);
      chk("update", W'(bus.update_o), W'(c_e.upd));
      chk("delta", bus.delta_o, c_e.d);
      chk("err", W'(bus.err_o), W'(c_e.err));
      chk("err_sticky", W'(bus.err_sticky_o), W'(c_e.stk));
    end else begin
      checks++;
      $display("FAIL scoreboard_empty: got no expected entry, required one at %0t", $time);
    end
  end

  task automatic hold(input logic [W-1:0] g, input logic clr, input int n);
    bus.gray_data_i = g;
    bus.clr_err_i   = clr;
    repeat (n) @(negedge clk);
  endtask

  task automatic random_phase(input int n);
    int r;
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 9);
      if (r < 4)      cur_b = (cur_b + 1) % (1 << W);
      else if (r < 6) cur_b = (cur_b + (1 << W) - 1) % (1 << W);
      else            cur_b = $urandom_range(0, (1 << W) - 1);
      hold(to_gray(cur_b), ($urandom_range(0, 7) == 0), $urandom_range(1, 4));
    end
  endtask

  initial begin
    bus.gray_data_i = 4'b0110;
    bus.clr_err_i   = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    hold(4'b0000, 1'b0, 4);
    hold(4'b0001, 1'b0, 6);
    // Full count including the 15 -> 0 wrap.
    for (int b = 2; b <= 16; b++) hold(to_gray(b % 16), 1'b0, 4);
    hold(4'b0011, 1'b0, 4);
    hold(4'b0001, 1'b0, 4);
    hold(4'b0000, 1'b0, 4);
    hold(4'b0010, 1'b0, 4);
    hold(4'b0101, 1'b0, 4);
    hold(4'b0101, 1'b1, 1);
    hold(4'b0101, 1'b0, 4);
    // Clear lands on the same edge as a fresh two-bit error.
    hold(4'b0000, 1'b0, 2);
    hold(4'b0000, 1'b1, 1);
    hold(4'b0000, 1'b0, 3);
    cur_b = 0;
    random_phase(200);
    bus.gray_data_i = 4'b1011;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    hold(4'b1011, 1'b0, 5);
    cur_b = 13;
    random_phase(150);
    hold(bus.gray_data_i, 1'b0, 6);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end
endmodule
